icmp_msg_scheduler: RTL and testbench
=====================================

Name: icmp_msg_scheduler

Overview:
- Shares one ICMP segmentation datapath among NREQ message requesters.
- Each requester presents one 5-word (160-bit) ICMP message, 32 bits per cycle.
- The block arbitrates round-robin, buffers the granted message, and computes the 16-bit ones'-complement ICMP checksum.
- It then emits the completed message word-by-word to the segmenter under a valid/ready handshake, with start and last markers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WORDS, 5, 32-bit words per ICMP message.
- DW, 32, word width; fixed at 32 for checksum field placement.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- hardreset  in  1  asynchronous, active-low reset (0 = reset).
- req  in  NREQ  per-requester request. Must stay high from first presentation until the last word is acked.
- req_data  in  NREQ*DW  flattened words; lane i is bits [i*DW +: DW].
- req_ack  out  NREQ  one-hot, one cycle per consumed word of the granted lane.
- grant  out  NREQ  one-hot owner of the datapath; 0 when idle.
- seg_data  out  DW  message word to the segmenter.
- seg_valid  out  1  seg_data is valid.
- seg_ready  in  1  segmenter accepts seg_data this cycle.
- seg_start  out  1  high with word 0.
- seg_last  out  1  high with word WORDS-1.
- busy  out  1  high in any state other than IDLE.
- abort  out  1  one-cycle pulse when a load is abandoned.

Behaviour:
- Reset: when hardreset is low, all outputs are 0 asynchronously. State is IDLE, the round-robin pointer is 0, and the buffer and accumulator are cleared. Reset mid-operation discards the message; no partial output is required.
- States and transitions: IDLE -> LOAD -> FOLD -> EMIT -> IDLE. LOAD -> IDLE on abort.
- IDLE:
  - If req != 0, pick the first set lane at or after the pointer (wrapping).
  - Next cycle: grant is registered one-hot, state = LOAD, word index = 0, accumulator = 0.
  - Pointer = granted lane + 1, mod NREQ.
- LOAD:
  - Each cycle, req_ack = grant and buf[index] <= granted lane's word; index increments.
  - Word 0 layout: [31:24] type, [23:16] code, [15:0] checksum field. The checksum field is treated as 0 for both the sum and the buffer.
  - The accumulator adds both 16-bit halves of every word; width is 20 bits (10 halves of at most 0xFFFF cannot overflow).
  - After index WORDS-1 is captured, go to FOLD.
- Abort: if the granted lane's req is low in any LOAD cycle, nothing is captured that cycle and req_ack = 0. abort pulses, grant clears, and the next state is IDLE. The pointer keeps its advanced value.
- FOLD (1 cycle):
  - s1 = acc[15:0] + acc[19:16].
  - s2 = s1[15:0] + s1[16].
  - csum = ~s2[15:0].
  - Write csum into buf[0][15:0].
- EMIT:
  - seg_valid = 1 and seg_data = buf[index], with index reset to 0 on entry.
  - seg_start = (index == 0); seg_last = (index == WORDS-1).
  - Index advances only when seg_valid and seg_ready. seg_data is held stable while seg_ready is low.
  - On acceptance of the last word, the next state is IDLE and grant clears.
- grant stays asserted through LOAD, FOLD and EMIT. req_ack is never asserted outside LOAD.
- Requests arriving during a busy period wait; no pre-emption.
- Latency: req seen in IDLE -> first req_ack 1 cycle later. First seg_valid comes 1 + WORDS + 1 cycles after req is seen. Minimum occupancy is 1 + WORDS + 1 + WORDS cycles.
- Back-to-back: IDLE samples req in the cycle after the last EMIT acceptance.

Decomposition:
- Shared package icmp_pkg:
  - state enum (IDLE, LOAD, FOLD, EMIT);
  - ICMP_WORDS = 5;
  - field positions TYPE_MSB/LSB, CODE_MSB/LSB, CSUM_MSB/LSB;
  - ICMP_ECHO_REQ = 8, ICMP_ECHO_REPLY = 0.
- One sub-module, icmp_csum_acc: clear/add-word/fold interface; outputs the 16-bit csum.
- Arbitration and FSM stay in the top level.

Test Plan:
- Basic checksum:
  - Stimulus: lane 0 sends 0x08000000, 0x00010001, 0, 0, 0 with seg_ready held at 1.
  - Response: req_ack[0] on 5 consecutive cycles, then seg_data 0x0800F7FD, 0x00010001, 0, 0, 0. seg_start on word 0, seg_last on word 4.
- Carry fold:
  - Stimulus: word0 = 0x00000000, words 1-4 = 0xFFFFFFFF.
  - Response: acc = 0x7FFF8, folded to 0xFFFF, so emitted word0 = 0x00000000.
- Checksum field ignored:
  - Stimulus: word0 = 0x0800ABCD, other words as in the basic checksum test.
  - Response: emitted word0 = 0x0800F7FD.
- Round robin:
  - Stimulus: req = 4'b1011 held continuously.
  - Response: grant sequence 0001, 0010, 1000, 0001, with each grant covering a full 5-word message.
- Backpressure:
  - Stimulus: seg_ready low for 3 cycles at word 2.
  - Response: seg_data is held at buf[2] and seg_valid stays 1; no word is skipped or duplicated; seg_last follows 2 accepted words later.
- Abort and reset:
  - Stimulus A: lane 2 drops req after 2 acks.
  - Response A: abort pulses for 1 cycle, grant = 0, no seg_valid; the next request is served from pointer = 3.
  - Stimulus B: hardreset driven low during EMIT.
  - Response B: all outputs go to 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/icmp_pkg.sv
// Shared types and ICMP header field positions for the message scheduler.
package icmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FOLD,
        ST_EMIT
    } state_t;

    localparam int unsigned ICMP_WORDS = 5;

    localparam int unsigned TYPE_MSB = 31;
    localparam int unsigned TYPE_LSB = 24;
    localparam int unsigned CODE_MSB = 23;
    localparam int unsigned CODE_LSB = 16;
    localparam int unsigned CSUM_MSB = 15;
    localparam int unsigned CSUM_LSB = 0;

    localparam logic [7:0] ICMP_ECHO_REQ   = 8'd8;
    localparam logic [7:0] ICMP_ECHO_REPLY = 8'd0;

endpackage

// File: rtl/icmp_msg_scheduler_if.sv
// Requester and segmenter signals of the scheduler; master is the scheduler side.
interface icmp_msg_scheduler_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ack;
    logic [NREQ-1:0]    grant;
    logic [DW-1:0]      seg_data;
    logic               seg_valid;
    logic               seg_ready;
    logic               seg_start;
    logic               seg_last;
    logic               busy;
    logic               abort;

    modport master (
        input  req, req_data, seg_ready,
        output req_ack, grant, seg_data, seg_valid, seg_start, seg_last, busy, abort
    );

    modport slave (
        output req, req_data, seg_ready,
        input  req_ack, grant, seg_data, seg_valid, seg_start, seg_last, busy, abort
    );
endinterface

// File: rtl/icmp_csum_acc.sv
// 20-bit halfword accumulator with an end-around-carry fold to the ICMP checksum.
module icmp_csum_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        add,
    input  logic [31:0] word,
    output logic [15:0] csum
);
    localparam int unsigned AW = 20;

    logic [AW-1:0] acc_q;
    logic [16:0]   s1;
    logic [15:0]   s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (add) begin
            acc_q <= acc_q + AW'(word[31:16]) + AW'(word[15:0]);
        end
    end

    // Two fold steps suffice: the first can carry at most one bit into bit 16.
    always_comb begin
        s1   = 17'(acc_q[15:0]) + 17'(acc_q[19:16]);
        s2   = s1[15:0] + 16'(s1[16]);
        csum = ~s2;
    end

endmodule

// File: rtl/icmp_msg_scheduler.sv
// Round-robin arbiter feeding one buffered ICMP message at a time through checksum insertion.
module icmp_msg_scheduler
    import icmp_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WORDS = ICMP_WORDS,
    parameter int unsigned DW    = 32
) (
    input  logic                 clock,
    input  logic                 hardreset,
    icmp_msg_scheduler_if.master bus
);
    localparam int unsigned     PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned     IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(WORDS - 1);
    localparam logic [PW:0]     NREQ_W   = (PW + 1)'(NREQ);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     widx_q, widx_d;
    logic              abort_q, abort_d;
    logic [DW-1:0]     msg_q [WORDS];

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [PW:0]       lane_sum;
    logic [PW:0]       ptr_inc;
    logic [PW-1:0]     pick;
    logic              pick_vld;

    logic [DW-1:0]     lane_word;
    logic [DW-1:0]     load_word;
    logic              req_ok;
    logic              capture;
    logic              acc_clr;
    logic              fold;
    logic [15:0]       csum;

    // Rotate requests so the pointer lane sits at bit 0; lowest set bit wins.
    always_comb begin
        req_dbl  = {bus.req, bus.req};
        req_rot  = NREQ'(req_dbl >> ptr_q);
        lane_sum = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                lane_sum = {1'b0, ptr_q} + (PW + 1)'(k);
                if (lane_sum >= NREQ_W) begin
                    lane_sum = lane_sum - NREQ_W;
                end
                pick     = lane_sum[PW-1:0];
                pick_vld = 1'b1;
            end
        end
        ptr_inc = {1'b0, pick} + (PW + 1)'(1);
        if (ptr_inc >= NREQ_W) begin
            ptr_inc = '0;
        end
    end

    // Granted lane's word, with the checksum field of word 0 forced to zero.
    always_comb begin
        lane_word = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (grant_q[k]) begin
                lane_word = lane_word | bus.req_data[k*DW +: DW];
            end
        end
        req_ok    = |(grant_q & bus.req);
        load_word = lane_word;
        if (widx_q == '0) begin
            load_word[CSUM_MSB:CSUM_LSB] = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        widx_d  = widx_q;
        abort_d = 1'b0;
        capture = 1'b0;
        acc_clr = 1'b0;
        fold    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d       = ST_LOAD;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    ptr_d         = ptr_inc[PW-1:0];
                    widx_d        = '0;
                    acc_clr       = 1'b1;
                end
            end
            ST_LOAD: begin
                if (!req_ok) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    abort_d = 1'b1;
                end else begin
                    capture = 1'b1;
                    if (widx_q == LAST_IDX) begin
                        state_d = ST_FOLD;
                        widx_d  = '0;
                    end else begin
                        widx_d = widx_q + IW'(1);
                    end
                end
            end
            ST_FOLD: begin
                fold    = 1'b1;
                state_d = ST_EMIT;
                widx_d  = '0;
            end
            ST_EMIT: begin
                if (bus.seg_ready) begin
                    if (widx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        widx_d  = '0;
                    end else begin
                        widx_d = widx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge hardreset) begin
        if (!hardreset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            widx_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            widx_q  <= widx_d;
            abort_q <= abort_d;
        end
    end

    always_ff @(posedge clock or negedge hardreset) begin
        if (!hardreset) begin
            for (int w = 0; w < int'(WORDS); w++) begin
                msg_q[w] <= '0;
            end
        end else if (capture) begin
            msg_q[widx_q] <= load_word;
        end else if (fold) begin
            msg_q[0][CSUM_MSB:CSUM_LSB] <= csum;
        end
    end

    icmp_csum_acc u_csum (
        .clk   (clock),
        .rst_n (hardreset),
        .clear (acc_clr),
        .add   (capture),
        .word  (load_word),
        .csum  (csum)
    );

    // Outputs decode registered state only, so they drop with reset without a clock edge.
    assign bus.req_ack   = (state_q == ST_LOAD) ? (grant_q & bus.req) : '0;
    assign bus.grant     = grant_q;
    assign bus.seg_valid = (state_q == ST_EMIT);
    assign bus.seg_data  = (state_q == ST_EMIT) ? msg_q[widx_q] : '0;
    assign bus.seg_start = (state_q == ST_EMIT) && (widx_q == '0);
    assign bus.seg_last  = (state_q == ST_EMIT) && (widx_q == LAST_IDX);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.abort     = abort_q;

endmodule

// File: tb/tb_icmp_msg_scheduler.sv
// Scoreboard bench: lane models feed messages, a monitor pops expected words on acceptance.
module tb_icmp_msg_scheduler;
    import icmp_pkg::*;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WORDS = ICMP_WORDS;
    localparam int unsigned DW    = 32;
    localparam int unsigned MEM   = 64;

    typedef struct {
        logic [31:0]     data;
        logic            start;
        logic            last;
        logic [NREQ-1:0] owner;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    icmp_msg_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

    icmp_msg_scheduler #(.NREQ(NREQ), .WORDS(WORDS), .DW(DW)) dut (
        .clock     (clk),
        .hardreset (rst_n),
        .bus       (bus)
    );

    exp_t               exp_q[$];
    int                 n_run = 0;
    int                 n_fail = 0;
    logic [31:0]        lane_mem [NREQ][MEM];
    int                 head [NREQ];
    int                 tail [NREQ];
    int                 drop_at [NREQ];
    int                 acks [NREQ];
    logic [NREQ-1:0]    ack_n;
    logic [NREQ-1:0]    req_v;
    logic [NREQ*DW-1:0] data_v;
    logic               ready_v;
    int                 stall_left;
    int                 wcnt;

    assign bus.req       = req_v;
    assign bus.req_data  = data_v;
    assign bus.seg_ready = ready_v;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference checksum: sum halfwords with word 0's checksum field zeroed, fold until no carry.
    function automatic logic [31:0] ref_word0(input logic [159:0] m);
        logic [31:0] sum;
        logic [31:0] w;
        sum = '0;
        for (int k = 0; k < int'(WORDS); k++) begin
            w = m[k*32 +: 32];
            if (k == 0) w[15:0] = 16'h0;
            sum = sum + {16'h0, w[31:16]} + {16'h0, w[15:0]};
        end
        while (sum[31:16] != 16'h0) sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
        return {m[31:16], ~sum[15:0]};
    endfunction

    function automatic logic [159:0] rnd_msg(input int lane);
        logic [159:0] m;
        for (int k = 0; k < int'(WORDS); k++) m[k*32 +: 32] = $urandom;
        m[TYPE_MSB:TYPE_LSB] = (lane % 2 == 1) ? ICMP_ECHO_REPLY : ICMP_ECHO_REQ;
        m[CODE_MSB:CODE_LSB] = 8'(lane);
        return m;
    endfunction

    function automatic bit lanes_empty();
        for (int i = 0; i < int'(NREQ); i++) if (head[i] != tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        for (int i = 0; i < int'(NREQ); i++) begin
            req_v[i] = (head[i] != tail[i]);
            data_v[i*DW +: DW] = req_v[i] ? lane_mem[i][head[i][5:0]] : 32'h0;
        end
    endtask

    // Queue a message on a lane; drop > 0 withdraws the request after that many acks.
    task automatic send(input int lane, input logic [159:0] m, input int drop);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[lane] = 1'b1;
        for (int k = 0; k < int'(WORDS); k++) begin
            lane_mem[lane][tail[lane][5:0]] = m[k*32 +: 32];
            tail[lane]++;
            if (drop == 0)
                exp_q.push_back('{data: (k == 0) ? ref_word0(m) : m[k*32 +: 32],
                                  start: (k == 0), last: (k == int'(WORDS) - 1), owner: oh});
        end
        drop_at[lane] = drop;
        acks[lane]    = 0;
        drive();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !bus.busy && lanes_empty()) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 400), 32'h1);
    endtask

    always @(negedge clk) ack_n = bus.req_ack;

    // Lane models: consume a word per observed ack.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (ack_n[i] && head[i] != tail[i]) begin
                head[i]++;
                acks[i]++;
                if (drop_at[i] != 0 && acks[i] == drop_at[i]) begin
                    head[i]    = tail[i];
                    drop_at[i] = 0;
                end
            end
        end
        drive();
    end

    // Monitor: ready is chosen here for the coming edge, so a word shown with ready=1 is consumed.
    always @(negedge clk) begin
        if (stall_left > 0 && wcnt == 2 && bus.seg_valid) begin
            ready_v = 1'b0;
            stall_left--;
        end else begin
            ready_v = 1'b1;
        end
        if (bus.seg_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'(bus.seg_valid), 32'h0);
            end else begin
                chk("seg_data", bus.seg_data, exp_q[0].data);
                chk("seg_start", 32'(bus.seg_start), 32'(exp_q[0].start));
                chk("seg_last", 32'(bus.seg_last), 32'(exp_q[0].last));
                chk("grant", 32'(bus.grant), 32'(exp_q[0].owner));
                if (ready_v) begin
                    void'(exp_q.pop_front());
                    wcnt = (wcnt == int'(WORDS) - 1) ? 0 : wcnt + 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [159:0] m;
        int n;
        rst_n = 1'b0;
        ready_v = 1'b1;
        req_v = '0;
        data_v = '0;
        wcnt = 0;
        stall_left = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            head[i] = 0; tail[i] = 0; drop_at[i] = 0; acks[i] = 0;
        end

        #22;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_valid", 32'(bus.seg_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ack", 32'(bus.req_ack), 32'h0);
        chk("rst_abort", 32'(bus.abort), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Round robin from pointer 0 with lanes 0,1,3 requesting twice each.
        for (int r = 0; r < 2; r++) begin
            send(0, rnd_msg(0), 0);
            send(1, rnd_msg(1), 0);
            send(3, rnd_msg(3), 0);
        end
        wait_idle("rr_done");

        // Basic checksum with ack run and FOLD bubble.
        m = {32'h0, 32'h0, 32'h0, 32'h00010001, 32'h08000000};
        send(0, m, 0);
        chk("basic_model", exp_q[0].data, 32'h0800F7FD);
        n = 0;
        do begin @(negedge clk); n++; end while (bus.req_ack == '0 && n < 20);
        chk("ack_first", 32'(bus.req_ack), 32'h1);
        repeat (4) begin
            @(negedge clk);
            chk("ack_run", 32'(bus.req_ack), 32'h1);
        end
        @(negedge clk);
        chk("fold_ack", 32'(bus.req_ack), 32'h0);
        chk("fold_valid", 32'(bus.seg_valid), 32'h0);
        @(negedge clk);
        chk("first_valid", 32'(bus.seg_valid), 32'h1);
        wait_idle("basic_done");

        // Stale checksum field ignored.
        m = {32'h0, 32'h0, 32'h0, 32'h00010001, 32'h0800ABCD};
        send(0, m, 0);
        wait_idle("csum_field_done");

        // End-around carry fold.
        m = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        send(0, m, 0);
        wait_idle("carry_done");

        // Backpressure: 3 stall cycles on word 2.
        stall_left = 3;
        send(1, rnd_msg(1), 0);
        wait_idle("bp_done");
        chk("bp_stalled", 32'(stall_left), 32'h0);

        // Abort: lane 2 withdraws after 2 acks.
        send(2, rnd_msg(2), 2);
        n = 0;
        while (!bus.abort && n < 30) begin @(negedge clk); n++; end
        chk("abort_seen", 32'(bus.abort), 32'h1);
        chk("abort_grant", 32'(bus.grant), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        chk("abort_pulse", 32'(bus.abort), 32'h0);
        wait_idle("abort_done");
        send(3, rnd_msg(3), 0);
        send(2, rnd_msg(2), 0);
        wait_idle("after_abort_done");

        // Asynchronous reset during EMIT.
        send(1, rnd_msg(1), 0);
        n = 0;
        while (!bus.seg_valid && n < 30) begin @(negedge clk); n++; end
        chk("emit_reached", 32'(bus.seg_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.seg_valid), 32'h0);
        chk("ar_grant", 32'(bus.grant), 32'h0);
        chk("ar_busy", 32'(bus.busy), 32'h0);
        chk("ar_data", bus.seg_data, 32'h0);
        chk("ar_start", 32'(bus.seg_start), 32'h0);
        exp_q.delete();
        wcnt = 0;
        for (int i = 0; i < int'(NREQ); i++) head[i] = tail[i];
        drive();
        @(negedge clk) rst_n = 1'b1;

        // Pointer back at 0 after reset: lane 1 before lane 2.
        send(1, rnd_msg(1), 0);
        send(2, rnd_msg(2), 0);
        wait_idle("recover_done");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
